// File: rtl/mdio_responder.sv
// Clause-22 MDIO management responder (PHY side) with a 32 x 16-bit register file.
// Optional build macro MDIO_PREAMBLE_SUPPRESS_EN: accept ST after a short preamble and flag it in reg1 bit 6.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [31:0] PHY_ID   = 32'h0181_B8A0
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    input  logic [15:0] status_in,
    output logic [15:0] ctrl_reg,
    output logic        wr_strobe,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_OP    = 3'd2;
    localparam logic [2:0] S_PHYAD = 3'd3;
    localparam logic [2:0] S_REGAD = 3'd4;
    localparam logic [2:0] S_TA    = 3'd5;
    localparam logic [2:0] S_DATA  = 3'd6;

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0]  PRE_MIN      = 6'd1;
    localparam logic [15:0] STATUS_FORCE = 16'h0040;
`else
    localparam logic [5:0]  PRE_MIN      = 6'd32;
    localparam logic [15:0] STATUS_FORCE = 16'h0000;
`endif

    logic [2:0]  mdc_sync;
    logic [1:0]  mdio_sync;
    logic        mdc_rise;
    logic        bit_in;

    logic [2:0]  state;
    logic [3:0]  bit_cnt;
    logic [5:0]  pre_cnt;
    logic [14:0] shift_in;
    logic        is_read;
    logic        skip;
    logic [4:0]  reg_addr;
    logic [15:0] rd_shift;
    logic        soft_rst;
    logic [15:0] rf [32];

    logic [4:0]  field;
    logic [15:0] wdata;
    logic [15:0] rd_value;
    logic        wr_ok;

    // mdc_rise is registered so it lands 3 sys_clk after the pin edge
    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            mdc_sync  <= 3'b000;
            mdio_sync <= 2'b11;
            mdc_rise  <= 1'b0;
        end else begin
            mdc_sync  <= {mdc_sync[1:0], mdc};
            mdio_sync <= {mdio_sync[0], mdio_i};
            mdc_rise  <= mdc_sync[1] & ~mdc_sync[2];
        end
    end

    assign bit_in   = mdio_sync[1];
    assign field    = {shift_in[3:0], bit_in};
    assign wdata    = {shift_in, bit_in};
    assign wr_ok    = (reg_addr == 5'd0) || (reg_addr > 5'd3);
    assign ctrl_reg = rf[0];

    always_comb begin
        rd_value = rf[field];
        case (field)
            5'd0:    rd_value = {1'b0, rf[0][14:0]};
            5'd1:    rd_value = status_in | STATUS_FORCE;
            5'd2:    rd_value = PHY_ID[31:16];
            5'd3:    rd_value = PHY_ID[15:0];
            default: rd_value = rf[field];
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state     <= S_IDLE;
            bit_cnt   <= 4'd0;
            pre_cnt   <= 6'd0;
            shift_in  <= 15'd0;
            is_read   <= 1'b0;
            skip      <= 1'b0;
            reg_addr  <= 5'd0;
            rd_shift  <= 16'd0;
            soft_rst  <= 1'b0;
            mdio_o    <= 1'b0;
            mdio_t    <= 1'b1;
            wr_strobe <= 1'b0;
            wr_addr   <= 5'd0;
            wr_data   <= 16'd0;
            for (int i = 0; i < 32; i++) rf[i] <= 16'd0;
        end else begin
            wr_strobe <= 1'b0;
            if (soft_rst) begin
                soft_rst <= 1'b0;
                for (int i = 0; i < 32; i++) rf[i] <= 16'd0;
            end
            if (mdc_rise) begin
                shift_in <= {shift_in[13:0], bit_in};
                bit_cnt  <= bit_cnt + 4'd1;
                case (state)
                    S_IDLE: begin
                        bit_cnt <= 4'd0;
                        if (bit_in) begin
                            if (pre_cnt != 6'd32) pre_cnt <= pre_cnt + 6'd1;
                        end else begin
                            pre_cnt <= 6'd0;
                            if (pre_cnt >= PRE_MIN) state <= S_START;
                        end
                    end
                    S_START: begin
                        bit_cnt <= 4'd0;
                        state   <= bit_in ? S_OP : S_IDLE;
                    end
                    S_OP: begin
                        if (bit_cnt[0]) begin
                            bit_cnt <= 4'd0;
                            // only 10 (read) and 01 (write) are legal opcodes
                            if (shift_in[0] != bit_in) begin
                                is_read <= shift_in[0];
                                state   <= S_PHYAD;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_PHYAD: begin
                        if (bit_cnt == 4'd4) begin
                            bit_cnt <= 4'd0;
                            skip    <= (field != PHY_ADDR);
                            state   <= S_REGAD;
                        end
                    end
                    S_REGAD: begin
                        if (bit_cnt == 4'd4) begin
                            bit_cnt  <= 4'd0;
                            reg_addr <= field;
                            rd_shift <= rd_value;
                            state    <= S_TA;
                        end
                    end
                    S_TA: begin
                        // output set at a rise is what the master samples on the next rise
                        if (!bit_cnt[0]) begin
                            if (is_read && !skip) begin
                                mdio_o <= 1'b0;
                                mdio_t <= 1'b0;
                            end
                        end else begin
                            bit_cnt <= 4'd0;
                            state   <= S_DATA;
                            if (is_read && !skip) begin
                                mdio_o   <= rd_shift[15];
                                rd_shift <= {rd_shift[14:0], 1'b0};
                            end
                        end
                    end
                    S_DATA: begin
                        if (bit_cnt == 4'd15) begin
                            state   <= S_IDLE;
                            bit_cnt <= 4'd0;
                            pre_cnt <= 6'd0;
                            mdio_t  <= 1'b1;
                            mdio_o  <= 1'b0;
                            if (!is_read && !skip && wr_ok) begin
                                rf[reg_addr] <= (reg_addr == 5'd0) ? {1'b0, wdata[14:0]} : wdata;
                                wr_strobe    <= 1'b1;
                                wr_addr      <= reg_addr;
                                wr_data      <= wdata;
                                soft_rst     <= (reg_addr == 5'd0) && wdata[15];
                            end
                        end else if (is_read && !skip) begin
                            mdio_o   <= rd_shift[15];
                            rd_shift <= {rd_shift[14:0], 1'b0};
                        end
                    end
                    default: begin
                        state   <= S_IDLE;
                        bit_cnt <= 4'd0;
                        pre_cnt <= 6'd0;
                    end
                endcase
            end
        end
    end

endmodule
